// File: rtl/stage_ex_mem_pkg.sv
// Shared pipeline definitions: bus widths, zero constants, stall-bit indices
// and the write-back payload carried between stages.
package stage_ex_mem_pkg;

  localparam int unsigned REG_W      = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned STALL_BUS_W = 6;

  localparam int unsigned STALL_PC  = 0;
  localparam int unsigned STALL_IF  = 1;
  localparam int unsigned STALL_ID  = 2;
  localparam int unsigned STALL_EX  = 3;
  localparam int unsigned STALL_MEM = 4;
  localparam int unsigned STALL_WB  = 5;

  typedef logic [REG_W-1:0]       reg_bus_t;
  typedef logic [REG_ADDR_W-1:0]  reg_addr_bus_t;
  typedef logic [STALL_BUS_W-1:0] stall_bus_t;

  localparam reg_bus_t      ZERO_WORD = REG_W'(0);
  localparam reg_addr_bus_t NOP_REG_ADDR = REG_ADDR_W'(0);

  typedef struct packed {
    reg_addr_bus_t waddr;
    logic          we;
    reg_bus_t      wdata;
  } wb_payload_t;

  // All-zero payload used for bubbles and reset.
  function automatic wb_payload_t bubble_payload();
    wb_payload_t p;
    p.waddr = NOP_REG_ADDR;
    p.we    = 1'b0;
    p.wdata = ZERO_WORD;
    return p;
  endfunction

endpackage

// File: rtl/stage_ex_mem_sat_counter.sv
// Saturating up-counter with synchronous clear; reused by per-stage
// performance counters.
module stage_ex_mem_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Clear beats increment; the all-ones value is sticky until cleared.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/stage_ex_mem.sv
// EX/MEM pipeline register: forwards the write-back triple one cycle later,
// turning EX stalls into counted bubbles and honouring MEM hold and flush.
module stage_ex_mem
  import stage_ex_mem_pkg::*;
#(
  parameter int unsigned STALL_W = 6,
  parameter int unsigned EX_BIT  = 3,
  parameter int unsigned MEM_BIT = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  reg_addr_bus_t      ex_reg_waddr,
  input  logic               ex_we,
  input  reg_bus_t           ex_reg_wdata,
  output reg_addr_bus_t      mem_reg_waddr,
  output logic               mem_we,
  output reg_bus_t           mem_reg_wdata,
  output logic               mem_valid,
  output logic [CNT_W-1:0]   bubble_cnt,
  input  logic               cnt_clr
);

  wb_payload_t slot_q;
  wb_payload_t slot_d;
  logic        valid_q;
  logic        valid_d;
  logic        ex_bubble_c;
  logic        stall_ex_c;
  logic        stall_mem_c;
  logic        unused_stall_c;

  assign stall_ex_c  = stall[EX_BIT];
  assign stall_mem_c = stall[MEM_BIT];
  // Remaining stall bits belong to other stages.
  assign unused_stall_c = ^stall;

  // Four-way select: flush, hold, EX bubble, capture.
  always_comb begin
    slot_d      = slot_q;
    valid_d     = valid_q;
    ex_bubble_c = 1'b0;
    if (flush) begin
      slot_d  = bubble_payload();
      valid_d = 1'b0;
    end else if (stall_mem_c) begin
      slot_d  = slot_q;
      valid_d = valid_q;
    end else if (stall_ex_c) begin
      slot_d      = bubble_payload();
      valid_d     = 1'b0;
      ex_bubble_c = 1'b1;
    end else begin
      slot_d.waddr = ex_reg_waddr;
      slot_d.we    = ex_we;
      slot_d.wdata = ex_reg_wdata;
      valid_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q  <= bubble_payload();
      valid_q <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      valid_q <= valid_d;
    end
  end

  stage_ex_mem_sat_counter #(
    .WIDTH (CNT_W)
  ) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (ex_bubble_c),
    .clr_i (cnt_clr),
    .cnt_o (bubble_cnt)
  );

  assign mem_reg_waddr = slot_q.waddr;
  assign mem_we        = slot_q.we;
  assign mem_reg_wdata = slot_q.wdata;
  assign mem_valid     = valid_q;

endmodule

// File: tb/tb_stage_ex_mem.sv
// Directed bench for stage_ex_mem with a 4-bit bubble counter so saturation
// is reachable quickly.
module tb_stage_ex_mem;
  import stage_ex_mem_pkg::*;

  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [5:0]       stall;
  logic             flush;
  reg_addr_bus_t    ex_reg_waddr;
  logic             ex_we;
  reg_bus_t         ex_reg_wdata;
  reg_addr_bus_t    mem_reg_waddr;
  logic             mem_we;
  reg_bus_t         mem_reg_wdata;
  logic             mem_valid;
  logic [CNT_W-1:0] bubble_cnt;
  logic             cnt_clr;

  int checks = 0;
  int errors = 0;

  stage_ex_mem #(
    .STALL_W (6),
    .EX_BIT  (3),
    .MEM_BIT (4),
    .CNT_W   (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .ex_reg_waddr  (ex_reg_waddr),
    .ex_we         (ex_we),
    .ex_reg_wdata  (ex_reg_wdata),
    .mem_reg_waddr (mem_reg_waddr),
    .mem_we        (mem_we),
    .mem_reg_wdata (mem_reg_wdata),
    .mem_valid     (mem_valid),
    .bubble_cnt    (bubble_cnt),
    .cnt_clr       (cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_mem(input string tag, input logic [4:0] a, input logic we,
                           input logic [31:0] d, input logic v);
    check({tag, ".waddr"}, 64'(mem_reg_waddr), 64'(a));
    check({tag, ".we"},    64'(mem_we),        64'(we));
    check({tag, ".wdata"}, 64'(mem_reg_wdata), 64'(d));
    check({tag, ".valid"}, 64'(mem_valid),     64'(v));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [4:0] a, input logic we, input logic [31:0] d);
    ex_reg_waddr = a;
    ex_we        = we;
    ex_reg_wdata = d;
  endtask

  initial begin
    rst = 1'b1; stall = 6'b0; flush = 1'b0; cnt_clr = 1'b0;
    set_ex(5'd0, 1'b0, 32'h0);

    // 1. reset, then pass-through
    tick(); tick();
    check_mem("reset", 5'd0, 1'b0, 32'h0, 1'b0);
    check("reset.cnt", 64'(bubble_cnt), 64'd0);
    rst = 1'b0;
    set_ex(5'd5, 1'b1, 32'hDEADBEEF);
    tick();
    check_mem("pass", 5'd5, 1'b1, 32'hDEADBEEF, 1'b1);

    // 2. EX stall produces counted bubbles
    stall = 6'b001111;
    set_ex(5'd7, 1'b1, 32'h12);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_mem("exstall", 5'd0, 1'b0, 32'h0, 1'b0);
    end
    check("exstall.cnt", 64'(bubble_cnt), 64'd3);

    // 3. MEM hold keeps outputs while EX inputs move
    stall = 6'b0;
    set_ex(5'd9, 1'b1, 32'hA5A5A5A5);
    tick();
    check_mem("load9", 5'd9, 1'b1, 32'hA5A5A5A5, 1'b1);
    stall = 6'b011111;
    for (int i = 0; i < 4; i++) begin
      set_ex(5'(i + 20), 1'(i[0]), 32'h1000 + 32'(i));
      tick();
      check_mem("hold", 5'd9, 1'b1, 32'hA5A5A5A5, 1'b1);
    end
    check("hold.cnt", 64'(bubble_cnt), 64'd3);

    // 4. flush beats MEM hold and is not counted
    stall = 6'b0;
    set_ex(5'd3, 1'b1, 32'h1);
    tick();
    check_mem("load3", 5'd3, 1'b1, 32'h1, 1'b1);
    stall = 6'b011111;
    flush = 1'b1;
    tick();
    check_mem("flush", 5'd0, 1'b0, 32'h0, 1'b0);
    check("flush.cnt", 64'(bubble_cnt), 64'd3);
    flush = 1'b0;

    // unrelated stall bits ignored; x0 write passes through
    stall = 6'b100111;
    set_ex(5'd0, 1'b1, 32'h55);
    tick();
    check_mem("x0", 5'd0, 1'b1, 32'h55, 1'b1);

    // 5. saturation, then clear wins over increment
    stall = 6'b001111;
    set_ex(5'd7, 1'b1, 32'h12);
    for (int i = 0; i < 20; i++) tick();
    check("sat.cnt", 64'(bubble_cnt), 64'd15);
    check("sat.valid", 64'(mem_valid), 64'd0);
    cnt_clr = 1'b1;
    tick();
    check("clr.cnt", 64'(bubble_cnt), 64'd0);
    cnt_clr = 1'b0;
    tick();
    check("postclr.cnt", 64'(bubble_cnt), 64'd1);

    // 6. reset during hold
    stall = 6'b0;
    set_ex(5'd11, 1'b1, 32'hCAFE);
    tick();
    check_mem("load11", 5'd11, 1'b1, 32'hCAFE, 1'b1);
    stall = 6'b011111;
    tick();
    check_mem("hold11", 5'd11, 1'b1, 32'hCAFE, 1'b1);
    rst = 1'b1;
    tick();
    check_mem("midrst", 5'd0, 1'b0, 32'h0, 1'b0);
    check("midrst.cnt", 64'(bubble_cnt), 64'd0);
    rst = 1'b0;
    tick();
    check_mem("rsthold", 5'd0, 1'b0, 32'h0, 1'b0);
    stall = 6'b0;
    set_ex(5'd12, 1'b0, 32'hBEEF);
    tick();
    check_mem("resume", 5'd12, 1'b0, 32'hBEEF, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
